pipo_write_arbiter: RTL and testbench
=====================================

Name: pipo_write_arbiter

Overview:
- Round-robin write arbiter that shares one N-bit PIPO load-enable register between NREQ requesters.
- Sits directly in front of the register. Drives its load strobe and parallel data, and returns a grant/done handshake to each requester.
- Moore FSM; all outputs are registered.

Parameters:
N, 8, data width of the shared register
NREQ, 4, number of requesters (2..8)
IDW, 2, width of the owner index; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NREQ  per-requester write request, level, held until done or withdrawn
req_data  input  NREQ*N  flattened write data; requester i uses bits [i*N +: N]
gnt  output  NREQ  one-hot grant, high in GRANT and LOAD
done  output  NREQ  one-hot, one-cycle write-complete pulse
load  output  1  load enable to the shared register
parallel_out  output  N  data to the shared register's parallel input
busy  output  1  high whenever the state is not IDLE
owner  output  IDW  index of the current or most recent grantee

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gnt=0, done=0, load=0, parallel_out=0, busy=0, owner=0.
  - Round-robin pointer ptr=0.
  - An asserted reset mid-transaction aborts the write immediately. No load and no done are produced.
- States: IDLE, GRANT, LOAD, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - Register sel=i and owner=i; next state GRANT.
- GRANT (1 cycle):
  - gnt[sel]=1 and busy=1.
  - If req[sel]=1: capture req_data[sel] into parallel_out; next state LOAD.
  - If req[sel]=0 (withdrawn): abort. Next state IDLE, ptr=sel+1 mod NREQ, no load, no done.
- LOAD (1 cycle):
  - load=1, gnt[sel]=1, parallel_out holds the captured data.
  - Withdrawal of req in this state is ignored; the write completes.
  - Next state DONE.
- DONE (1 cycle):
  - done[sel]=1, gnt=0, load=0.
  - ptr=sel+1 mod NREQ; next state IDLE.
- Latency: req first seen high in IDLE at edge t → gnt at t+1, load at t+2, done at t+3, IDLE at t+4.
  - Minimum spacing between successive writes is 4 cycles.
- Requester obligation:
  - Drop req in the cycle after done.
  - A req still high in IDLE is treated as a new request.
- Simultaneous requests: exactly one is granted. All others wait; no request is lost while req stays high.
- Fairness: with all NREQ requesters continuously requesting, grant order is 0,1,...,NREQ-1,0,...
- Pointer wrap: sel=NREQ-1 sets ptr=0.
- parallel_out holds its last value outside LOAD. The shared register ignores it while load=0.
- Bits of req at indices >= NREQ do not exist. owner never exceeds NREQ-1.

Optional Feature:
- Macro: PIPO_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest asserted index always wins.
  - ptr is not implemented and the search always starts at 0.
- Undefined: round-robin as described above.
- Handshake, FSM and latency are identical in both builds.

Test Plan:
1. Hold reset=0 for 3 cycles, then release → all outputs 0, busy=0, owner=0; no load while req=0.
2. req=4'b0100, req_data[2]=8'hA5 → gnt=4'b0100 at t+1; load=1 with parallel_out=8'hA5 at t+2; done=4'b0100 at t+3. Downstream register reads 8'hA5.
3. req=4'b1111 held, distinct data per requester → grant order 0,1,2,3,0. Exactly one load every 4 cycles, each with the matching data.
   - With PIPO_ARB_FIXED_PRIO_EN defined: requester 0 wins every time.
4. Requester 1 drops req during GRANT → return to IDLE, no load, no done. The next grant goes to the next requester after 1 if one is waiting.
5. Assert reset=0 during LOAD → load=0, gnt=0 immediately (asynchronous). done never pulses; state is IDLE after release.
6. Requester 3 granted (ptr wraps), then req=4'b1001 → requester 0 granted next; owner=0.

Source files
------------

// File: rtl/pipo_write_arbiter_if.sv
// Handshake and data bundle between the requesters, the write arbiter and
// the shared PIPO register.
// master: arbiter side (drives grant/done/load/data/status).
// slave : requester/register side (drives requests and write data).
interface pipo_write_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              load;
  logic [N-1:0]      parallel_out;
  logic              busy;
  logic [IDW-1:0]    owner;

  modport master (
    input  req, req_data,
    output gnt, done, load, parallel_out, busy, owner
  );

  modport slave (
    output req, req_data,
    input  gnt, done, load, parallel_out, busy, owner
  );
endinterface

// File: rtl/pipo_write_arbiter.sv
// Write arbiter sharing one N-bit PIPO load-enable register between NREQ
// requesters. Moore FSM IDLE -> GRANT -> LOAD -> DONE; every output is
// registered. Default build is round-robin; defining PIPO_ARB_FIXED_PRIO_EN
// selects fixed priority (lowest asserted index wins, no rotating pointer).
module pipo_write_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pipo_write_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Next index modulo NREQ; sel = NREQ-1 wraps to 0.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(NREQ - 1)) ? {IDW{1'b0}} : v + IDW'(1);
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      v[k] = (i == IDW'(k));
    end
    return v;
  endfunction

  state_t          state_r, state_s;
  logic [IDW-1:0]  sel_r, sel_s;
  logic [IDW-1:0]  owner_r, owner_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic            load_r, load_s;
  logic [N-1:0]    pout_r, pout_s;
  logic            busy_r, busy_s;
  logic [IDW-1:0]  start_s;
  logic [IDW-1:0]  cand_s;
  logic [IDW-1:0]  pick_s;
  logic            found_s;
  logic [N-1:0]    sel_data_s;

`ifdef PIPO_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at requester 0.
  assign start_s = {IDW{1'b0}};
`else
  logic [IDW-1:0] ptr_r, ptr_s;
  assign start_s = ptr_r;
`endif

  // Search for the first asserted request starting at start_s, wrapping.
  always_comb begin
    cand_s  = start_s;
    pick_s  = {IDW{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pick_s  = (!found_s && bus.req[cand_s]) ? cand_s : pick_s;
      found_s = found_s | bus.req[cand_s];
      cand_s  = wrap_inc(cand_s);
    end
  end

  // Write data of the current grantee.
  always_comb begin
    sel_data_s = {N{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_data_s = (sel_r == IDW'(i)) ? bus.req_data[i*N +: N] : sel_data_s;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    owner_s = owner_r;
    gnt_s   = {NREQ{1'b0}};
    done_s  = {NREQ{1'b0}};
    load_s  = 1'b0;
    pout_s  = pout_r;
`ifndef PIPO_ARB_FIXED_PRIO_EN
    ptr_s   = ptr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_GRANT;
          sel_s   = pick_s;
          owner_s = pick_s;
          gnt_s   = onehot(pick_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.req[sel_r]) begin
          state_s = ST_LOAD;
          gnt_s   = onehot(sel_r);
          load_s  = 1'b1;
          pout_s  = sel_data_s;
        end else begin
          // Request withdrawn: abort without load or done.
          state_s = ST_IDLE;
`ifndef PIPO_ARB_FIXED_PRIO_EN
          ptr_s   = wrap_inc(sel_r);
`endif
        end
      end
      ST_LOAD: begin
        // Write is committed; a withdrawal here is ignored.
        state_s = ST_DONE;
        done_s  = onehot(sel_r);
      end
      ST_DONE: begin
        state_s = ST_IDLE;
`ifndef PIPO_ARB_FIXED_PRIO_EN
        ptr_s   = wrap_inc(sel_r);
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      sel_r   <= {IDW{1'b0}};
      owner_r <= {IDW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      load_r  <= 1'b0;
      pout_r  <= {N{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      owner_r <= owner_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      load_r  <= load_s;
      pout_r  <= pout_s;
      busy_r  <= busy_s;
    end
  end

`ifndef PIPO_ARB_FIXED_PRIO_EN
  // Round-robin pointer: one past the last grantee.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= {IDW{1'b0}};
    end else begin
      ptr_r <= ptr_s;
    end
  end
`endif

  assign bus.gnt          = gnt_r;
  assign bus.done         = done_r;
  assign bus.load         = load_r;
  assign bus.parallel_out = pout_r;
  assign bus.busy         = busy_r;
  assign bus.owner        = owner_r;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Scoreboard bench for pipo_write_arbiter: stimulus pushes expected loads
// and done pulses into queues; a negedge monitor pops and compares them.
module tb_pipo_write_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] owner;
    logic [N-1:0]   data;
  } load_exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   load_count;
  logic [N-1:0] shadow_reg;

  load_exp_t       load_q[$];
  logic [NREQ-1:0] done_q[$];

  pipo_write_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus_if ();

  pipo_write_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream PIPO register model.
  always @(posedge clk or negedge reset) begin
    if (!reset) shadow_reg <= '0;
    else if (bus_if.load) shadow_reg <= bus_if.parallel_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every load and done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus_if.load === 1'b1) begin
      load_count++;
      if (load_q.size() == 0) begin
        check("load_unexpected", 32'd1, 32'd0);
      end else begin
        load_exp_t e;
        e = load_q.pop_front();
        check("load_owner", 32'(bus_if.owner), 32'(e.owner));
        check("load_data", 32'(bus_if.parallel_out), 32'(e.data));
        check("load_gnt", 32'(bus_if.gnt), 32'(4'b0001 << e.owner));
      end
    end
    if (bus_if.done !== 4'b0000) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'(bus_if.done), 32'd0);
      end else begin
        check("done_vec", 32'(bus_if.done), 32'(done_q.pop_front()));
      end
    end
  end

  // One complete write: request, grant, load, done, then drop the request.
  task automatic do_write(input logic [3:0] r, input logic [1:0] exp_own, input logic [7:0] exp_data);
    load_q.push_back('{owner: exp_own, data: exp_data});
    done_q.push_back(4'b0001 << exp_own);
    bus_if.req = r;
    tick();
    check("wr_gnt", 32'(bus_if.gnt), 32'(4'b0001 << exp_own));
    check("wr_owner", 32'(bus_if.owner), 32'(exp_own));
    check("wr_busy", 32'(bus_if.busy), 32'd1);
    tick();
    tick();
    bus_if.req = 4'b0000;
    tick();
    check("wr_idle_busy", 32'(bus_if.busy), 32'd0);
    check("wr_shadow", 32'(shadow_reg), 32'(exp_data));
  endtask

  logic [1:0] rr_own [5];
  logic [7:0] rr_data[5];

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    load_count = 0;
    reset      = 1'b0;
    bus_if.req = 4'b0000;
    bus_if.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};

    // 1: reset and idle behaviour
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_gnt", 32'(bus_if.gnt), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_load", 32'(bus_if.load), 32'd0);
    check("rst_pout", 32'(bus_if.parallel_out), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_owner", 32'(bus_if.owner), 32'd0);
    repeat (3) tick();
    check("idle_no_load", 32'(load_count), 32'd0);

    // 2: single request from requester 2
    do_write(4'b0100, 2'd2, 8'hA5);

    // 3: all requesting continuously, from a freshly reset pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus_if.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef PIPO_ARB_FIXED_PRIO_EN
    rr_own  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    rr_data = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
`else
    rr_own  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
`endif
    for (int k = 0; k < 5; k++) begin
      load_q.push_back('{owner: rr_own[k], data: rr_data[k]});
      done_q.push_back(4'b0001 << rr_own[k]);
    end
    load_count = 0;
    bus_if.req = 4'b1111;
    for (int k = 0; k < 19; k++) begin
      tick();
      if ((k % 4) == 0) check("rr_owner", 32'(bus_if.owner), 32'(rr_own[k/4]));
    end
    bus_if.req = 4'b0000;
    repeat (2) tick();
    check("rr_load_count", 32'(load_count), 32'd5);

    // 4: requester 1 withdraws in GRANT; requester 2 is served next
    bus_if.req = 4'b0110;
    tick();
    check("wd_gnt", 32'(bus_if.gnt), 32'b0010);
    bus_if.req = 4'b0100;
    tick();
    check("wd_abort_gnt", 32'(bus_if.gnt), 32'd0);
    check("wd_abort_load", 32'(bus_if.load), 32'd0);
    check("wd_abort_busy", 32'(bus_if.busy), 32'd0);
    do_write(4'b0100, 2'd2, 8'hC2);

    // 5: reset during LOAD aborts the write
    bus_if.req = 4'b0001;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_load", 32'(bus_if.load), 32'd0);
    check("rst_mid_gnt", 32'(bus_if.gnt), 32'd0);
    tick();
    bus_if.req = 4'b0000;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_mid_busy", 32'(bus_if.busy), 32'd0);

    // 6: pointer wrap after requester 3, then 1001 goes to requester 0
    do_write(4'b0100, 2'd2, 8'hC2);
    do_write(4'b1000, 2'd3, 8'hD3);
    do_write(4'b1001, 2'd0, 8'hA0);

    repeat (2) tick();
    check("load_q_empty", 32'(load_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
